// File: rtl/pid_output_stage_if.sv
// pid_output_stage_if: sample/history/increment/control bundle between the
// sampler side (master) and the PID output stage (slave).
interface pid_output_stage_if #(
  parameter int DATA_W = 9,
  parameter int U_W    = 16
);
  logic              sample_req;
  logic              clr;
  logic [DATA_W-1:0] setpoint;
  logic [DATA_W-1:0] feedback;
  logic [DATA_W:0]   ek0;
  logic [DATA_W:0]   ek1;
  logic [DATA_W:0]   ek2;
  logic [14:0]       d_uk;
  logic [U_W-1:0]    u;
  logic              u_valid;
  logic              busy;
  logic              sat;
  logic              overrun;
  modport master (
    output sample_req, clr, setpoint, feedback, d_uk,
    input  ek0, ek1, ek2, u, u_valid, busy, sat, overrun
  );
  modport slave (
    input  sample_req, clr, setpoint, feedback, d_uk,
    output ek0, ek1, ek2, u, u_valid, busy, sat, overrun
  );
endinterface

// File: rtl/pid_output_stage.sv
// pid_output_stage: forms e(k), shifts the error history into the increment unit and
// integrates the returned d_uk into a clamped u(k); PID_DEADBAND_EN zeroes small errors.
module pid_output_stage #(
  parameter int                    DATA_W   = 9,
  parameter int                    U_W      = 16,
  parameter logic signed [U_W-1:0] U_MIN    = -16'sd2048,
  parameter logic signed [U_W-1:0] U_MAX    = 16'sd2047,
  parameter logic signed [U_W-1:0] U_INIT   = '0,
  parameter int                    DEADBAND = 2
) (
  input logic               clk,
  input logic               rst_n,
  pid_output_stage_if.slave bus
);
  localparam int E_W = DATA_W + 1;
  typedef enum logic [2:0] {IDLE, CAPTURE, SETTLE, ACCUM, DONE} state_t;
  state_t                  r_state;
  logic [DATA_W-1:0]       r_sp, r_fb;
  logic signed [E_W-1:0]   r_ek0, r_ek1, r_ek2;
  logic signed [14:0]      r_d;
  logic signed [U_W-1:0]   r_u;
  logic                    r_u_valid, r_sat, r_overrun;
  logic signed [E_W-1:0]   w_e, w_e_in;
  logic signed [U_W:0]     w_sum;
  logic                    w_hi, w_lo;
  assign w_e = $signed({1'b0, r_sp}) - $signed({1'b0, r_fb});
`ifdef PID_DEADBAND_EN
  assign w_e_in = (w_e <= E_W'(DEADBAND) && w_e >= -E_W'(DEADBAND)) ? '0 : w_e;
`else
  assign w_e_in = w_e;
`endif
  assign w_sum = (U_W+1)'(r_u) + (U_W+1)'(r_d);
  assign w_hi  = w_sum > (U_W+1)'(U_MAX);
  assign w_lo  = w_sum < (U_W+1)'(U_MIN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sp      <= '0;
      r_fb      <= '0;
      r_ek0     <= '0;
      r_ek1     <= '0;
      r_ek2     <= '0;
      r_d       <= '0;
      r_u       <= U_INIT;
      r_u_valid <= 1'b0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (bus.clr) begin
      r_state   <= IDLE;
      r_ek0     <= '0;
      r_ek1     <= '0;
      r_ek2     <= '0;
      r_u       <= U_INIT;
      r_u_valid <= 1'b0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_u_valid <= 1'b0;
      r_sat     <= 1'b0;
      if (bus.sample_req && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (bus.sample_req) begin
          r_sp    <= bus.setpoint;
          r_fb    <= bus.feedback;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_ek2   <= r_ek1;
          r_ek1   <= r_ek0;
          r_ek0   <= w_e_in;
          r_state <= SETTLE;
        end
        SETTLE: begin
          r_d     <= $signed(bus.d_uk);
          r_state <= ACCUM;
        end
        // u_valid/sat are registered here so they are visible during DONE
        ACCUM: begin
          r_u       <= w_hi ? U_MAX : w_lo ? U_MIN : w_sum[U_W-1:0];
          r_sat     <= w_hi | w_lo;
          r_u_valid <= 1'b1;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ek0     = r_ek0;
  assign bus.ek1     = r_ek1;
  assign bus.ek2     = r_ek2;
  assign bus.u       = r_u;
  assign bus.u_valid = r_u_valid;
  assign bus.sat     = r_sat;
  assign bus.busy    = r_state != IDLE;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_pid_output_stage.sv
// tb_pid_output_stage: directed checks of the PID output stage against a
// behavioural increment unit d_uk = kp*(e0-e1) + ki*e0 + kd*(e0-2e1+e2).
module tb_pid_output_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   kp, ki, kd;
  int   e0, e1, e2, d_calc;
  pid_output_stage_if #(.DATA_W(9), .U_W(16)) bus ();
  pid_output_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always_comb begin
    e0         = int'($signed(bus.ek0));
    e1         = int'($signed(bus.ek1));
    e2         = int'($signed(bus.ek2));
    d_calc     = kp * (e0 - e1) + ki * e0 + kd * (e0 - 2 * e1 + e2);
    bus.d_uk   = d_calc[14:0];
  end
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_sample(input int sp, input int fb, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.sample_req = 1'b1;
    bus.setpoint   = sp[8:0];
    bus.feedback   = fb[8:0];
    @(negedge clk);
    bus.sample_req = 1'b0;
    for (int i = 2; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.u_valid) lat = i;
    end
    chk({tag, "_latency"}, lat, 4);
  endtask
  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask
  task automatic no_valid(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.u_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.sample_req = 1'b0;
    bus.clr = 1'b0;
    bus.setpoint = '0;
    bus.feedback = '0;
    kp = 0; ki = 1; kd = 0;
    repeat (2) @(negedge clk);
    chk("rst_ek0", $signed(bus.ek0), 0);
    chk("rst_ek1", $signed(bus.ek1), 0);
    chk("rst_ek2", $signed(bus.ek2), 0);
    chk("rst_u", $signed(bus.u), 0);
    chk("rst_flags", {bus.u_valid, bus.busy, bus.sat, bus.overrun}, 0);
    rst_n = 1'b1;
    // first sample: e = 40, u = 40
    do_sample(100, 60, "s1");
    chk("s1_ek0", $signed(bus.ek0), 40);
    chk("s1_ek1", $signed(bus.ek1), 0);
    chk("s1_u", $signed(bus.u), 40);
    chk("s1_sat", bus.sat, 0);
    chk("s1_busy", bus.busy, 1);
    @(negedge clk);
    chk("s1_pulse", bus.u_valid, 0);
    chk("s1_idle", bus.busy, 0);
    // history over three samples
    pulse_clr();
    do_sample(110, 100, "h1");
    do_sample(120, 100, "h2");
    do_sample(105, 100, "h3");
    chk("h_ek0", $signed(bus.ek0), 5);
    chk("h_ek1", $signed(bus.ek1), 20);
    chk("h_ek2", $signed(bus.ek2), 10);
    chk("h_u", $signed(bus.u), 35);
    // positive and negative saturation
    pulse_clr();
    ki = 15;
    do_sample(511, 0, "sp1");
    chk("sp1_u", $signed(bus.u), 2047);
    chk("sp1_sat", bus.sat, 1);
    do_sample(511, 0, "sp2");
    chk("sp2_u", $signed(bus.u), 2047);
    chk("sp2_sat", bus.sat, 1);
    pulse_clr();
    do_sample(0, 511, "sn1");
    chk("sn1_u", $signed(bus.u), -2048);
    chk("sn1_sat", bus.sat, 1);
    do_sample(0, 511, "sn2");
    chk("sn2_u", $signed(bus.u), -2048);
    chk("sn2_sat", bus.sat, 1);
    // request while busy
    pulse_clr();
    ki = 1;
    @(negedge clk);
    bus.sample_req = 1'b1; bus.setpoint = 9'd100; bus.feedback = 9'd60;
    @(negedge clk);
    bus.sample_req = 1'b0;
    @(negedge clk);
    bus.sample_req = 1'b1; bus.setpoint = 9'd200;
    @(negedge clk);
    bus.sample_req = 1'b0;
    @(negedge clk);
    chk("ovr_valid", bus.u_valid, 1);
    chk("ovr_u", $signed(bus.u), 40);
    chk("ovr_flag", bus.overrun, 1);
    no_valid(6, "ovr_single");
    pulse_clr();
    chk("clr_ovr", bus.overrun, 0);
    chk("clr_u", $signed(bus.u), 0);
    chk("clr_ek", {bus.ek0, bus.ek1, bus.ek2}, 0);
    // clr wins over a simultaneous request
    @(negedge clk);
    bus.sample_req = 1'b1; bus.clr = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0; bus.clr = 1'b0;
    chk("clrreq_busy", bus.busy, 0);
    chk("clrreq_ovr", bus.overrun, 0);
    no_valid(5, "clrreq_novalid");
    // clr during SETTLE
    do_sample(100, 60, "pre");
    @(negedge clk);
    bus.sample_req = 1'b1; bus.setpoint = 9'd100; bus.feedback = 9'd60;
    @(negedge clk);
    bus.sample_req = 1'b0;
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    chk("abt_busy", bus.busy, 0);
    chk("abt_u", $signed(bus.u), 0);
    chk("abt_ek0", $signed(bus.ek0), 0);
    no_valid(6, "abt_novalid");
    do_sample(100, 60, "abt_next");
    chk("abt_next_ek1", $signed(bus.ek1), 0);
    chk("abt_next_u", $signed(bus.u), 40);
    // reset during ACCUM
    @(negedge clk);
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rsta_u", $signed(bus.u), 0);
    chk("rsta_busy", bus.busy, 0);
    chk("rsta_ek0", $signed(bus.ek0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid(6, "rsta_novalid");
    do_sample(100, 60, "rsta_next");
    chk("rsta_next_ek1", $signed(bus.ek1), 0);
    chk("rsta_next_u", $signed(bus.u), 40);
    // deadband boundary
    pulse_clr();
    do_sample(50, 48, "db1");
`ifdef PID_DEADBAND_EN
    chk("db1_ek0", $signed(bus.ek0), 0);
    chk("db1_u", $signed(bus.u), 0);
`else
    chk("db1_ek0", $signed(bus.ek0), 2);
    chk("db1_u", $signed(bus.u), 2);
`endif
    do_sample(50, 47, "db2");
    chk("db2_ek0", $signed(bus.ek0), 3);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
